// File: rtl/dmac_arb_pkg.sv
// Shared types and helpers for the DMAC bus arbiter.
// AHB transfer encodings, arbiter states and index-width helper.
package dmac_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        BUSY   = 2'b01,
        NONSEQ = 2'b10,
        SEQ    = 2'b11
    } htrans_t;

    typedef enum logic {
        PARK = 1'b0,
        OWN  = 1'b1
    } arb_state_t;

    function automatic int midx_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/dmac_rr_picker.sv
// Rotating-mask priority selector over a request vector.
// rr=1 searches upward from ptr+1 with wrap; rr=0 picks lowest index.
module dmac_rr_picker
    import dmac_arb_pkg::*;
#(
    parameter int N = 2,
    parameter int W = 1
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    input  logic [N-1:0] excl,
    input  logic         rr,
    output logic         valid,
    output logic [W-1:0] idx
);

    logic [N-1:0] cand;

    assign cand = req & ~excl;

    always_comb begin
        int j;
        logic [W-1:0] jw;
        j = 0;
        jw = '0;
        valid = 1'b0;
        idx = '0;
        for (int k = 0; k < N; k++) begin
            j = rr ? (int'(ptr) + 1 + k) % N : k;
            jw = W'(j);
            if (!valid && cand[jw]) begin
                valid = 1'b1;
                idx = jw;
            end
        end
    end

endmodule

// File: rtl/dmac_bus_arbiter.sv
// AHB master-side arbiter sharing one master port between requesters.
// Handover only on HReady; optional hold-limit preemption and lock.
module dmac_bus_arbiter
    import dmac_arb_pkg::*;
#(
    parameter int NUM_MASTERS    = 2,
    parameter int DEFAULT_MASTER = 0,
    parameter int ROUND_ROBIN    = 1,
    parameter int MAX_HOLD       = 8,
    localparam int W  = midx_w(NUM_MASTERS),
    localparam int HW = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_MASTERS-1:0] Bus_Req,
    input  logic [NUM_MASTERS-1:0] Bus_Lock,
    input  logic                   HReady,
    input  logic [1:0]             HTrans,
    output logic [NUM_MASTERS-1:0] Bus_Grant,
    output logic [W-1:0]           HMaster,
    output logic [W-1:0]           HMasterData,
    output logic                   Preempt
);

    localparam logic [W-1:0]  DEF_IDX  = W'(DEFAULT_MASTER);
    localparam logic [HW-1:0] HOLD_MAX = HW'(MAX_HOLD);
    localparam logic          RR_MODE  = (ROUND_ROBIN != 0);

    arb_state_t state_q, state_d;
    logic [W-1:0] owner_q, owner_d;
    logic [W-1:0] rr_q, rr_d;
    logic [W-1:0] hmd_q;
    logic [HW-1:0] hold_q, hold_d;
    logic [NUM_MASTERS-1:0] grant_q;
    logic [NUM_MASTERS-1:0] owner_mask;
    logic [NUM_MASTERS-1:0] excl;
    logic preempt_q, preempt_d;
    logic pick_vld;
    logic [W-1:0] pick_idx;
    logic others;
    logic beat;
    logic can_pre;
    htrans_t ht;

    assign ht = htrans_t'(HTrans);
    assign owner_mask = NUM_MASTERS'(1) << owner_q;
    assign excl = (state_q == OWN) ? owner_mask : '0;
    assign others = |(Bus_Req & ~owner_mask);
    assign beat = (ht == NONSEQ) || (ht == SEQ);

    // Only an idle, unlocked owner past its hold budget can be displaced
    assign can_pre = (MAX_HOLD != 0) && (hold_q >= HOLD_MAX)
                  && others && !Bus_Lock[owner_q]
                  && (ht == IDLE) && pick_vld;

    dmac_rr_picker #(
        .N(NUM_MASTERS),
        .W(W)
    ) u_pick (
        .req  (Bus_Req),
        .ptr  (rr_q),
        .excl (excl),
        .rr   (RR_MODE),
        .valid(pick_vld),
        .idx  (pick_idx)
    );

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        rr_d = rr_q;
        hold_d = hold_q;
        preempt_d = 1'b0;
        if (HReady) begin
            unique case (state_q)
                PARK: begin
                    if (pick_vld) begin
                        owner_d = pick_idx;
                        rr_d = pick_idx;
                        state_d = OWN;
                        hold_d = '0;
                    end
                end
                OWN: begin
                    if (!Bus_Req[owner_q]) begin
                        hold_d = '0;
                        if (pick_vld) begin
                            owner_d = pick_idx;
                            rr_d = pick_idx;
                        end else begin
                            owner_d = DEF_IDX;
                            state_d = PARK;
                        end
                    end else if (can_pre) begin
                        owner_d = pick_idx;
                        rr_d = pick_idx;
                        hold_d = '0;
                        preempt_d = 1'b1;
                    end else if (beat && hold_q != HOLD_MAX) begin
                        hold_d = hold_q + 1'b1;
                    end
                end
                default: state_d = PARK;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= PARK;
            owner_q <= DEF_IDX;
            rr_q <= DEF_IDX;
            hmd_q <= DEF_IDX;
            hold_q <= '0;
            grant_q <= NUM_MASTERS'(1) << DEF_IDX;
            preempt_q <= 1'b0;
        end else begin
            preempt_q <= preempt_d;
            if (HReady) begin
                state_q <= state_d;
                owner_q <= owner_d;
                rr_q <= rr_d;
                hold_q <= hold_d;
                hmd_q <= owner_q;
                grant_q <= NUM_MASTERS'(1) << owner_d;
            end
        end
    end

    assign Bus_Grant = grant_q;
    assign HMaster = owner_q;
    assign HMasterData = hmd_q;
    assign Preempt = preempt_q;

endmodule

// File: tb/tb_dmac_bus_arbiter.sv
// Self-checking bench: behavioural arbiter model plus directed scenarios.
// Randomised traffic is compared against the model every cycle.
module tb_dmac_bus_arbiter;

    localparam int N  = 4;
    localparam int MH = 4;
    localparam int D  = 0;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [N-1:0] Bus_Req = '0;
    logic [N-1:0] Bus_Lock = '0;
    logic HReady = 1'b1;
    logic [1:0] HTrans = 2'b00;
    logic [N-1:0] Bus_Grant;
    logic [1:0] HMaster;
    logic [1:0] HMasterData;
    logic Preempt;

    int checks = 0;
    int failures = 0;

    int m_owner = D;
    int m_rr = D;
    int m_hold = 0;
    int m_hmd = D;
    bit m_own = 1'b0;
    bit m_pre = 1'b0;
    bit m_valid = 1'b0;

    always #5 clk = ~clk;

    dmac_bus_arbiter #(
        .NUM_MASTERS(N),
        .DEFAULT_MASTER(D),
        .ROUND_ROBIN(1),
        .MAX_HOLD(MH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .Bus_Req(Bus_Req),
        .Bus_Lock(Bus_Lock),
        .HReady(HReady),
        .HTrans(HTrans),
        .Bus_Grant(Bus_Grant),
        .HMaster(HMaster),
        .HMasterData(HMasterData),
        .Preempt(Preempt)
    );

    function automatic int m_pick(input logic [N-1:0] r, input int ex);
        for (int k = 1; k <= N; k++) begin
            int j;
            j = (m_rr + k) % N;
            if (j != ex && r[j]) return j;
        end
        return -1;
    endfunction

    always @(posedge clk) begin : model
        int o, h, r, p, hmd;
        bit own, pre;
        o = m_owner; h = m_hold; r = m_rr; own = m_own;
        hmd = m_hmd; pre = 1'b0; p = -1;
        if (rst) begin
            o = D; h = 0; r = D; own = 1'b0; hmd = D;
        end else if (HReady) begin
            hmd = m_owner;
            if (!m_own) begin
                if (Bus_Req != 0) begin
                    p = m_pick(Bus_Req, -1);
                    o = p; r = p; own = 1'b1; h = 0;
                end
            end else if (!Bus_Req[m_owner]) begin
                h = 0;
                if (Bus_Req != 0) begin
                    p = m_pick(Bus_Req, m_owner);
                    o = p; r = p;
                end else begin
                    o = D; own = 1'b0;
                end
            end else if (m_hold >= MH
                         && (Bus_Req & ~(N'(1) << m_owner)) != 0
                         && !Bus_Lock[m_owner] && HTrans == 2'b00) begin
                p = m_pick(Bus_Req, m_owner);
                o = p; r = p; h = 0; pre = 1'b1;
            end else if (HTrans[1] && m_hold < MH) begin
                h = m_hold + 1;
            end
        end
        if (rst) m_valid <= 1'b1;
        m_owner <= o; m_hold <= h; m_rr <= r;
        m_own <= own; m_hmd <= hmd; m_pre <= pre;
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d t=%0t",
                     nm, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
        if (m_valid) begin
            chk("m_grant", int'(Bus_Grant), 1 << m_owner);
            chk("m_hmaster", int'(HMaster), m_owner);
            chk("m_hmdata", int'(HMasterData), m_hmd);
            chk("m_preempt", int'(Preempt), int'(m_pre));
            chk("m_onehot", $countones(Bus_Grant), 1);
        end
    endtask

    task automatic lit(input string nm, input logic [N-1:0] g,
                       input int hm, input int hmd, input bit pre);
        chk({nm, "_grant"}, int'(Bus_Grant), int'(g));
        chk({nm, "_hmaster"}, int'(HMaster), hm);
        chk({nm, "_hmdata"}, int'(HMasterData), hmd);
        chk({nm, "_preempt"}, int'(Preempt), int'(pre));
    endtask

    task automatic do_reset();
        rst = 1'b1; Bus_Req = '0; Bus_Lock = '0;
        HReady = 1'b1; HTrans = 2'b00;
        cyc();
        rst = 1'b0;
    endtask

    task automatic burst4();
        HTrans = 2'b10;
        cyc();
        chk("burst_nonseq", int'(Bus_Grant), 2);
        for (int i = 0; i < 3; i++) begin
            HTrans = 2'b11;
            cyc();
            chk("burst_seq", int'(Bus_Grant), 2);
        end
    endtask

    logic [N-1:0] rr_seq [4];
    logic [N-1:0] cur;

    initial begin
        rr_seq[0] = 4'b0100; rr_seq[1] = 4'b1000;
        rr_seq[2] = 4'b0001; rr_seq[3] = 4'b0010;

        do_reset();
        cyc();
        for (int i = 0; i < 10; i++) begin
            cyc();
            lit("park", 4'b0001, 0, 0, 1'b0);
        end

        Bus_Req = 4'b0010;
        cyc();
        lit("grant1", 4'b0010, 1, 0, 1'b0);
        cyc();
        lit("grant1_data", 4'b0010, 1, 1, 1'b0);
        Bus_Req = 4'b0000;
        cyc();
        lit("release", 4'b0001, 0, 1, 1'b0);

        HReady = 1'b0;
        Bus_Req = 4'b0010;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("stall_grant", int'(Bus_Grant), 1);
        end
        HReady = 1'b1;
        cyc();
        chk("stall_done", int'(Bus_Grant), 2);
        Bus_Req = 4'b0000;
        cyc();

        do_reset();
        Bus_Req = 4'b0011;
        cyc();
        chk("pre_grant", int'(Bus_Grant), 2);
        burst4();
        HTrans = 2'b00;
        cyc();
        lit("preempt", 4'b0001, 0, 1, 1'b1);
        cyc();
        chk("preempt_pulse_end", int'(Preempt), 0);

        do_reset();
        Bus_Lock = 4'b0010;
        Bus_Req = 4'b0011;
        cyc();
        chk("lock_grant", int'(Bus_Grant), 2);
        burst4();
        HTrans = 2'b00;
        cyc();
        lit("lock_hold", 4'b0010, 1, 1, 1'b0);
        cyc();
        lit("lock_hold2", 4'b0010, 1, 1, 1'b0);
        Bus_Lock = 4'b0000;
        cyc();
        lit("unlock_pre", 4'b0001, 0, 1, 1'b1);

        do_reset();
        Bus_Req = 4'b1111;
        cyc();
        chk("rr_first", int'(Bus_Grant), 2);
        cur = 4'b0010;
        for (int i = 0; i < 4; i++) begin
            Bus_Req = 4'b1111 & ~cur;
            cyc();
            chk("rr_step", int'(Bus_Grant), int'(rr_seq[i]));
            cur = rr_seq[i];
            Bus_Req = 4'b1111;
            cyc();
            chk("rr_keep", int'(Bus_Grant), int'(cur));
        end

        do_reset();
        Bus_Req = 4'b0010;
        cyc();
        HTrans = 2'b10;
        cyc();
        HTrans = 2'b11;
        cyc();
        HReady = 1'b0;
        rst = 1'b1;
        cyc();
        lit("mid_rst", 4'b0001, 0, 0, 1'b0);
        rst = 1'b0;
        HReady = 1'b1;
        Bus_Req = 4'b0011;
        HTrans = 2'b00;
        cyc();
        chk("mid_rst_regrant", int'(Bus_Grant), 2);
        cyc();
        chk("mid_rst_nopre", int'(Preempt), 0);

        for (int i = 0; i < 4000; i++) begin
            rst = ($urandom_range(0, 499) == 0);
            if ($urandom_range(0, 9) < 3)
                Bus_Req = N'($urandom_range(0, 15));
            if ($urandom_range(0, 9) < 2)
                Bus_Lock = N'($urandom_range(0, 15)) & N'($urandom_range(0, 15));
            HReady = ($urandom_range(0, 9) < 8);
            HTrans = 2'($urandom_range(0, 3));
            cyc();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
